// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small program memory plus an IDLE/RUN/HALT
// sequencer that presents each instruction word to the control unit for a
// number of cycles determined by the word's two-bit type field.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5,
  parameter int STD_CYC     = 3,
  parameter int LOAD_CYC    = 4,
  parameter int STORE_CYC   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   halted
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int MAX_A = (STD_CYC > LOAD_CYC) ? STD_CYC : LOAD_CYC;
  localparam int MAX_N = (MAX_A > STORE_CYC) ? MAX_A : STORE_CYC;
  // The first word after run is held one extra cycle, so the counter must
  // reach MAX_N + 1 without wrapping.
  localparam int CNT_W = $clog2(MAX_N + 2);

  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0]   pc_next;
  logic [INSTR_WIDTH-1:0] word0;
  logic [INSTR_WIDTH-1:0] next_word;

  // Hold length for a word, taken from its top two bits (type 00 = halt).
  function automatic logic [CNT_W-1:0] hold_of(input logic [INSTR_WIDTH-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    case (w[INSTR_WIDTH-1 -: 2])
      2'b01:   n = CNT_W'(STD_CYC);
      2'b10:   n = CNT_W'(LOAD_CYC);
      2'b11:   n = CNT_W'(STORE_CYC);
      default: n = '0;
    endcase
    return n;
  endfunction

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
    return (w[INSTR_WIDTH-1 -: 2] == 2'b00);
  endfunction

  // Combinational reads; a write on the same edge as a fetch is seen only
  // by later fetches, so the fetch gets the pre-write content.
  assign pc_next   = pc_q + ADDR_BITS'(1);
  assign word0     = mem_q[ADDR_ZERO];
  assign next_word = mem_q[pc_next];

  // Program memory write port: only while the sequencer is not running.
  // No reset here, so the program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q != S_RUN)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Sequencer state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start fetch on run, count down holds, advance or halt.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          pc_d = '0;
          if (is_halt(word0)) begin
            instr_d = '0;
            cnt_d   = '0;
            state_d = S_HALT;
          end else begin
            // Extra lead-in cycle while the control unit leaves reset.
            instr_d = word0;
            cnt_d   = hold_of(word0) + CNT_ONE;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          pc_d = pc_next;
          if (is_halt(next_word)) begin
            instr_d = '0;
            cnt_d   = '0;
            state_d = S_HALT;
          end else begin
            instr_d = next_word;
            cnt_d   = hold_of(next_word);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        instr_d = '0;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign busy   = (state_q == S_RUN);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven per-cycle vectors whose
// expected outputs go through a scoreboard queue, plus hand-written
// sequences for address wrap and asynchronous reset.
module tb_instr_fetch;

  typedef struct packed {
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
  } obs_t;

  typedef struct {
    logic        run;
    logic        we;
    logic [4:0]  addr;
    logic [19:0] data;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];
  vec_t tbl[$];

  localparam logic [19:0] STD  = 20'h40000;
  localparam logic [19:0] LOAD = 20'h80000;
  localparam logic [19:0] STOR = 20'hC0000;

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .instr     (instr),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic obs_t ob(input logic [19:0] i, input logic [4:0] p,
                              input logic b, input logic h);
    obs_t o;
    o.instr = i; o.pc = p; o.busy = b; o.halted = h;
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                              input logic [19:0] d, input obs_t e);
    vec_t v;
    v.run = r; v.we = w; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string name, input obs_t e);
    obs_t a;
    a = ob(instr, pc, busy, halted);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got instr=%h pc=%0d busy=%b halted=%b, want instr=%h pc=%0d busy=%b halted=%b",
               name, a.instr, a.pc, a.busy, a.halted, e.instr, e.pc, e.busy, e.halted);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input string name, input logic r, input logic w,
                      input logic [4:0] a, input logic [19:0] d, input obs_t e);
    obs_t ex;
    run = r; prog_we = w; prog_addr = a; prog_data = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    run = 1'b0; prog_we = 1'b0;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      ex = exp_q.pop_front();
      compare(name, ex);
    end
    $display("cyc %s run=%b we=%b -> instr=%h pc=%0d busy=%b halted=%b",
             name, r, w, instr, pc, busy, halted);
  endtask

  task automatic idle_n(input string name, input int n, input obs_t e);
    for (int i = 0; i < n; i++) step(name, 1'b0, 1'b0, 5'd0, 20'd0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compare("reset_state", ob(20'd0, 5'd0, 1'b0, 1'b0));
    rst = 1'b1;

    // Basic std/halt program, run ignored mid-run, write ignored in RUN.
    tbl.push_back(mk(0, 1, 5'd0, STD,   ob(0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 5'd1, 20'd0, ob(0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    tbl.push_back(mk(0, 1, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 1, 0, 1)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 1, 0, 1)));
    // mem[0] must still be the std word.
    tbl.push_back(mk(1, 0, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(STD, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 1, 0, 1)));
    // Load / store / halt program written in HALT.
    tbl.push_back(mk(0, 1, 5'd0, LOAD,  ob(0, 1, 0, 1)));
    tbl.push_back(mk(0, 1, 5'd1, STOR,  ob(0, 1, 0, 1)));
    tbl.push_back(mk(0, 1, 5'd2, 20'd0, ob(0, 1, 0, 1)));
    tbl.push_back(mk(1, 0, 5'd0, 20'd0, ob(LOAD, 0, 1, 0)));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(LOAD, 0, 1, 0)));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(STOR, 1, 1, 0)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 2, 0, 1)));
    // run + write of mem[0] on the same edge: fetch sees the old word.
    tbl.push_back(mk(1, 1, 5'd0, 20'd0, ob(LOAD, 0, 1, 0)));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(LOAD, 0, 1, 0)));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(STOR, 1, 1, 0)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 2, 0, 1)));
    // Now mem[0] is a halt word: run halts immediately at pc 0.
    tbl.push_back(mk(1, 0, 5'd0, 20'd0, ob(0, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 5'd0, 20'd0, ob(0, 0, 0, 1)));

    foreach (tbl[k]) begin
      step($sformatf("vec%0d", k), tbl[k].run, tbl[k].we, tbl[k].addr,
           tbl[k].data, tbl[k].exp);
    end

    // Fill all words with std, pc walks and wraps, busy never drops.
    for (int a = 0; a < 32; a++) step("fill", 1'b0, 1'b1, 5'(a), STD, ob(0, 0, 0, 1));
    step("wrap_start", 1'b1, 1'b0, 5'd0, 20'd0, ob(STD, 0, 1, 0));
    idle_n("wrap_pc0", 3, ob(STD, 0, 1, 0));
    for (int p = 1; p < 32; p++) idle_n($sformatf("wrap_pc%0d", p), 3, ob(STD, 5'(p), 1, 0));
    idle_n("wrap_back0", 3, ob(STD, 0, 1, 0));
    idle_n("wrap_pc1b", 1, ob(STD, 1, 1, 0));

    // Asynchronous reset between edges while running.
    #3 rst = 1'b0;
    #1 compare("async_rst_a", ob(0, 0, 0, 0));
    #2 rst = 1'b1;
    idle_n("idle_after_rst", 2, ob(0, 0, 0, 0));

    // Run again and reset during the hold of pc=3.
    step("rerun", 1'b1, 1'b0, 5'd0, 20'd0, ob(STD, 0, 1, 0));
    idle_n("rr_pc0", 3, ob(STD, 0, 1, 0));
    idle_n("rr_pc1", 3, ob(STD, 1, 1, 0));
    idle_n("rr_pc2", 3, ob(STD, 2, 1, 0));
    idle_n("rr_pc3", 1, ob(STD, 3, 1, 0));
    #3 rst = 1'b0;
    #1 compare("async_rst_pc3", ob(0, 0, 0, 0));
    step("held_in_rst", 1'b1, 1'b0, 5'd0, 20'd0, ob(0, 0, 0, 0));
    #4 rst = 1'b1;
    idle_n("wait_idle", 2, ob(0, 0, 0, 0));

    // Memory survived reset: mem[0] still std; terminate at word 1.
    step("set_halt1", 1'b0, 1'b1, 5'd1, 20'd0, ob(0, 0, 0, 0));
    step("post_rst_run", 1'b1, 1'b0, 5'd0, 20'd0, ob(STD, 0, 1, 0));
    idle_n("post_rst_hold", 3, ob(STD, 0, 1, 0));
    idle_n("post_rst_halt", 2, ob(0, 1, 0, 1));

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
